// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the data-memory bridge.
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RWAIT = 2'd2,
        RESP  = 2'd3
    } bridge_state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_BITS      = 2;

    // Halfword must sit on an even address, word on a multiple of 4; bytes never misalign.
    function automatic logic is_misaligned(input logic [BYTES_PER_WORD-1:0] be,
                                           input logic [LANE_BITS-1:0]      off);
        logic mis;
        mis = 1'b0;
        if ((be == 4'b0011) && off[0])
            mis = 1'b1;
        if ((be == 4'b1111) && (off != 2'b00))
            mis = 1'b1;
        return mis;
    endfunction

endpackage

// File: rtl/data_mem_bridge_lane_align.sv
// Byte-lane steering between lane-0 based core data and the word-wide bus.
module lane_align
    import mem_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 31
) (
    input  logic [LANE_BITS-1:0]      off,
    input  logic [BYTES_PER_WORD-1:0] be,
    input  logic [DATA_WIDTH:0]       wdata,
    input  logic [DATA_WIDTH:0]       rdata,
    output logic [BYTES_PER_WORD-1:0] be_c,
    output logic [DATA_WIDTH:0]       wdata_c,
    output logic [DATA_WIDTH:0]       rdata_c
);

    // Shift by the byte offset; anything pushed past lane 3 falls off the top.
    always_comb begin
        be_c    = be << off;
        wdata_c = wdata << {off, 3'b000};
        rdata_c = rdata >> {off, 3'b000};
    end

endmodule

// File: rtl/data_mem_bridge.sv
// Core data port to req/gnt/rvalid bus bridge with stall and timeout.
// Optional: define MISALIGN_TRAP_EN to trap misaligned accesses instead of issuing them.
module data_mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 31,
    parameter int unsigned DATA_WIDTH     = 31,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_read_req,
    input  logic [ADDR_WIDTH:0]       i_read_addr,
    output logic [DATA_WIDTH:0]       o_read_data,
    input  logic                      i_write_enable,
    input  logic [BYTES_PER_WORD-1:0] i_byte_enable,
    input  logic [ADDR_WIDTH:0]       i_write_addr,
    input  logic [DATA_WIDTH:0]       i_write_data,
    output logic                      o_stall,
    output logic                      o_bus_err,
    output logic                      o_mem_req,
    output logic                      o_mem_we,
    output logic [BYTES_PER_WORD-1:0] o_mem_be,
    output logic [ADDR_WIDTH:0]       o_mem_addr,
    output logic [DATA_WIDTH:0]       o_mem_wdata,
    input  logic                      i_mem_gnt,
    input  logic                      i_mem_rvalid,
    input  logic [DATA_WIDTH:0]       i_mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    bridge_state_e             state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]       addr_q, addr_d;
    logic [BYTES_PER_WORD-1:0] be_q, be_d;
    logic [DATA_WIDTH:0]       wdata_q, wdata_d;
    logic                      we_q, we_d;
    logic [DATA_WIDTH:0]       rdata_q, rdata_d;
    logic                      skip_q, skip_d;

    logic [ADDR_WIDTH:0]       req_addr_c;
    logic                      req_present_c;
    logic [BYTES_PER_WORD-1:0] be_sh_c;
    logic [DATA_WIDTH:0]       wdata_sh_c;
    logic [DATA_WIDTH:0]       rdata_sh_c;

    lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane_align (
        .off     (addr_q[LANE_BITS-1:0]),
        .be      (be_q),
        .wdata   (wdata_q),
        .rdata   (i_mem_rdata),
        .be_c    (be_sh_c),
        .wdata_c (wdata_sh_c),
        .rdata_c (rdata_sh_c)
    );

    // Write wins over a simultaneous read; the cycle after retirement ignores the still-visible request.
    assign req_addr_c    = i_write_enable ? i_write_addr : i_read_addr;
    assign req_present_c = (i_write_enable | i_read_req) & ~skip_q;

    // State, timeout counter and access registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            skip_q  <= skip_d;
        end
    end

    // Next-state and bus/core outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rdata_d     = rdata_q;
        skip_d      = 1'b0;
        o_stall     = 1'b0;
        o_bus_err   = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_be    = '0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_read_data = '0;

        unique case (state_q)
            IDLE: begin
                if (req_present_c) begin
                    o_stall = 1'b1;
                    addr_d  = req_addr_c;
                    be_d    = i_byte_enable;
                    wdata_d = i_write_enable ? i_write_data : '0;
                    we_d    = i_write_enable;
                    rdata_d = '0;
                    cnt_d   = '0;
`ifdef MISALIGN_TRAP_EN
                    if (is_misaligned(i_byte_enable, req_addr_c[LANE_BITS-1:0])) begin
                        o_bus_err = 1'b1;
                        state_d   = RESP;
                    end else begin
                        state_d   = REQ;
                    end
`else
                    state_d = REQ;
`endif
                end
            end

            REQ: begin
                o_stall = 1'b1;
                if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    o_bus_err = 1'b1;
                    state_d   = RESP;
                end else begin
                    o_mem_req   = 1'b1;
                    o_mem_we    = we_q;
                    o_mem_be    = we_q ? be_sh_c : {BYTES_PER_WORD{1'b1}};
                    o_mem_addr  = {addr_q[ADDR_WIDTH:LANE_BITS], {LANE_BITS{1'b0}}};
                    o_mem_wdata = we_q ? wdata_sh_c : '0;
                    if (i_mem_gnt) begin
                        state_d = we_q ? RESP : RWAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end

            RWAIT: begin
                o_stall = 1'b1;
                if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    o_bus_err = 1'b1;
                    state_d   = RESP;
                end else if (i_mem_rvalid) begin
                    rdata_d = rdata_sh_c;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            RESP: begin
                o_read_data = we_q ? '0 : rdata_q;
                skip_d      = 1'b1;
                state_d     = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
